// File: rtl/forwarding_control_unit_if.sv
// Decode-side bundle for the forwarding control unit: instruction in,
// operand-source selects, immediate, stall and DM-stage destination out.
interface forwarding_control_unit_if;
    logic [23:0] ins;
    logic        ins_valid;
    logic [1:0]  mux_sel_A;
    logic [1:0]  mux_sel_B;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        stall;
    logic [4:0]  RW_dm;
    logic        we_dm;

    modport master (
        output ins, ins_valid,
        input  mux_sel_A, mux_sel_B, imm_sel, imm, stall, RW_dm, we_dm
    );

    modport slave (
        input  ins, ins_valid,
        output mux_sel_A, mux_sel_B, imm_sel, imm, stall, RW_dm, we_dm
    );
endinterface

// File: rtl/forwarding_control_unit.sv
// Operand forwarding and load-use stall control: tracks the last three issue
// slots and picks the nearest in-flight producer for each source register.
module forwarding_control_unit (
    input  logic                        clk,
    input  logic                        rst,
    forwarding_control_unit_if.slave    bus
);
    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
    } hist_t;

    hist_t       r_h1, r_h2, r_h3;
    logic [1:0]  r_sel_a, r_sel_b;
    logic        r_imm_sel;
    logic [7:0]  r_imm;
    logic [4:0]  r_rw_dm;
    logic        r_we_dm;

    logic [1:0]  w_class;
    logic [4:0]  w_rd, w_rs, w_rt;
    logic        w_reads_rt;
    logic        w_stall;
    logic        w_accept;
    hist_t       w_new;
    logic [1:0]  w_sel_a, w_sel_b;

    // Nearest producer wins: h1 is checked before h2 before h3.
    function automatic logic [1:0] fwd_sel(input logic [4:0] f, input hist_t a,
                                           input hist_t b, input hist_t c);
        logic [1:0] s;
        s = 2'b00;
        if (a.wen && f == a.rd)      s = 2'b01;
        else if (b.wen && f == b.rd) s = 2'b10;
        else if (c.wen && f == c.rd) s = 2'b11;
        return s;
    endfunction

    always_comb begin
        w_class    = bus.ins[23:22];
        w_rd       = bus.ins[18:14];
        w_rs       = bus.ins[13:9];
        w_rt       = bus.ins[8:4];
        w_reads_rt = (w_class == 2'b00) || (w_class == 2'b11);
        w_stall    = bus.ins_valid && r_h1.wen && r_h1.is_load &&
                     ((w_rs == r_h1.rd) || (w_reads_rt && (w_rt == r_h1.rd)));
        w_accept   = bus.ins_valid && !w_stall;
        w_new      = '{rd: w_rd, wen: (w_class != 2'b11), is_load: (w_class == 2'b10)};
        w_sel_a    = fwd_sel(w_rs, r_h1, r_h2, r_h3);
        w_sel_b    = w_reads_rt ? fwd_sel(w_rt, r_h1, r_h2, r_h3) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h1      <= '0;
            r_h2      <= '0;
            r_h3      <= '0;
            r_sel_a   <= '0;
            r_sel_b   <= '0;
            r_imm_sel <= 1'b0;
            r_imm     <= '0;
            r_rw_dm   <= '0;
            r_we_dm   <= 1'b0;
        end else begin
            // A rejected slot still advances the pipeline, inserting a bubble.
            r_h1    <= w_accept ? w_new : '0;
            r_h2    <= r_h1;
            r_h3    <= r_h2;
            r_rw_dm <= r_h1.rd;
            r_we_dm <= r_h1.wen;
            if (w_accept) begin
                r_sel_a   <= w_sel_a;
                r_sel_b   <= w_sel_b;
                r_imm_sel <= (w_class == 2'b01) || (w_class == 2'b10);
                r_imm     <= bus.ins[7:0];
            end else begin
                r_sel_a   <= '0;
                r_sel_b   <= '0;
                r_imm_sel <= 1'b0;
                r_imm     <= '0;
            end
        end
    end

    assign bus.mux_sel_A = r_sel_a;
    assign bus.mux_sel_B = r_sel_b;
    assign bus.imm_sel   = r_imm_sel;
    assign bus.imm       = r_imm;
    assign bus.stall     = w_stall;
    assign bus.RW_dm     = r_rw_dm;
    assign bus.we_dm     = r_we_dm;
endmodule

// File: tb/tb_forwarding_control_unit.sv
// Scoreboard bench for forwarding_control_unit: directed hazard scenarios
// followed by randomized traffic against a slot-history reference model.
module tb_forwarding_control_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    forwarding_control_unit_if bus ();

    forwarding_control_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0] rd;
        bit         wen;
        bit         ld;
    } slot_t;

    typedef struct {
        bit         stall;
        logic [1:0] a;
        logic [1:0] b;
        bit         isel;
        logic [7:0] imm;
        logic [4:0] rw;
        bit         we;
    } exp_t;

    slot_t hist[$];
    exp_t  sbq[$];
    int    checks = 0;
    int    errors = 0;
    bit    done   = 1'b0;
    bit    inited = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void clear_hist();
        slot_t z;
        z = '{rd: 5'd0, wen: 1'b0, ld: 1'b0};
        hist.delete();
        repeat (3) hist.push_back(z);
    endfunction

    // Distance (1..3) to the most recent slot that writes f, 0 if none.
    function automatic logic [1:0] producer_dist(input logic [4:0] f);
        for (int k = 0; k < 3; k++)
            if (hist[k].wen && hist[k].rd == f) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic bit reads_rt(input logic [23:0] x);
        return (x[23:22] == 2'd0) || (x[23:22] == 2'd3);
    endfunction

    function automatic bit load_use(input bit v, input logic [23:0] x);
        return v && hist[0].wen && hist[0].ld &&
               (x[13:9] == hist[0].rd || (reads_rt(x) && x[8:4] == hist[0].rd));
    endfunction

    task automatic step(input bit r, input bit v, input logic [23:0] x, output bit stalled);
        exp_t  e;
        slot_t s;
        bit    pre;
        @(negedge clk);
        rst           = r;
        bus.ins_valid = v;
        bus.ins       = x;
        pre = load_use(v, x);
        e = '{stall: 1'b0, a: 2'd0, b: 2'd0, isel: 1'b0, imm: 8'd0, rw: 5'd0, we: 1'b0};
        if (r) begin
            clear_hist();
        end else begin
            e.rw = hist[0].rd;
            e.we = hist[0].wen;
            s = '{rd: 5'd0, wen: 1'b0, ld: 1'b0};
            if (v && !pre) begin
                e.a    = producer_dist(x[13:9]);
                e.b    = reads_rt(x) ? producer_dist(x[8:4]) : 2'd0;
                e.isel = (x[23:22] == 2'd1) || (x[23:22] == 2'd2);
                e.imm  = x[7:0];
                s = '{rd: x[18:14], wen: (x[23:22] != 2'd3), ld: (x[23:22] == 2'd2)};
            end
            hist.push_front(s);
            void'(hist.pop_back());
        end
        // Inputs stay put across the edge, so stall afterwards uses the new history.
        e.stall = load_use(v, x);
        sbq.push_back(e);
        #1;
        if (inited) chk("stall_pre_edge", {7'd0, bus.stall}, {7'd0, pre});
        if (r) inited = 1'b1;
        stalled = pre && !r;
    endtask

    task automatic issue(input logic [23:0] x);
        bit st;
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, x, st);
            if (!st) break;
        end
    endtask

    task automatic idle(input int n);
        bit st;
        repeat (n) step(1'b0, 1'b0, 24'd0, st);
    endtask

    function automatic logic [23:0] mkr(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 4'h0};
    endfunction

    function automatic logic [23:0] mki(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [7:0] im);
        return {op, rd, rs, 1'b0, im};
    endfunction

    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stall",     {7'd0, bus.stall},     {7'd0, e.stall});
                chk("mux_sel_A", {6'd0, bus.mux_sel_A}, {6'd0, e.a});
                chk("mux_sel_B", {6'd0, bus.mux_sel_B}, {6'd0, e.b});
                chk("imm_sel",   {7'd0, bus.imm_sel},   {7'd0, e.isel});
                chk("imm",       bus.imm,               e.imm);
                chk("RW_dm",     {3'd0, bus.RW_dm},     {3'd0, e.rw});
                chk("we_dm",     {7'd0, bus.we_dm},     {7'd0, e.we});
            end
        end
    end

    initial begin
        bit st;
        logic [23:0] x;
        rst = 1'b1;
        bus.ins_valid = 1'b0;
        bus.ins = '0;
        clear_hist();
        step(1'b1, 1'b0, 24'd0, st);
        step(1'b1, 1'b1, mkr(5'b00000, 5'd1, 5'd1, 5'd1), st);
        issue(mkr(5'b00000, 5'd9, 5'd0, 5'd0));       // first after reset: all 00
        idle(3);

        issue(mkr(5'b00000, 5'd3, 5'd1, 5'd2));        // back-to-back RAW on both sources
        issue(mkr(5'b00001, 5'd4, 5'd3, 5'd3));
        idle(3);

        issue(mki(5'b01000, 5'd5, 5'd0, 8'h11));       // distance 3, then 4
        issue(mkr(5'b00000, 5'd10, 5'd12, 5'd12));
        issue(mkr(5'b00000, 5'd11, 5'd12, 5'd12));
        issue(mkr(5'b00000, 5'd13, 5'd5, 5'd14));
        issue(mki(5'b01000, 5'd5, 5'd0, 8'h11));
        issue(mkr(5'b00000, 5'd10, 5'd12, 5'd12));
        issue(mkr(5'b00000, 5'd11, 5'd12, 5'd12));
        issue(mkr(5'b00000, 5'd13, 5'd12, 5'd12));
        issue(mkr(5'b00000, 5'd14, 5'd5, 5'd12));
        idle(3);

        issue(mki(5'b10000, 5'd6, 5'd1, 8'h04));       // load-use on rt
        issue(mkr(5'b00000, 5'd8, 5'd1, 5'd6));
        idle(3);

        issue(mkr(5'b00000, 5'd7, 5'd1, 5'd1));        // r7 at h3 and h1
        issue(mkr(5'b00000, 5'd9, 5'd1, 5'd1));
        issue(mkr(5'b00000, 5'd7, 5'd2, 5'd2));
        issue(mkr(5'b00000, 5'd12, 5'd7, 5'd7));
        issue(mkr(5'b11000, 5'd15, 5'd1, 5'd2));       // store writes nothing
        issue(mkr(5'b00000, 5'd16, 5'd15, 5'd15));
        idle(3);

        issue(mki(5'b01010, 5'd2, 5'd1, 8'hA5));
        idle(3);

        issue(mki(5'b10000, 5'd6, 5'd1, 8'h00));       // reset overrides a pending stall
        step(1'b1, 1'b1, mkr(5'b00000, 5'd8, 5'd6, 5'd6), st);
        step(1'b0, 1'b1, mkr(5'b00000, 5'd8, 5'd6, 5'd6), st);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            x = {5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 4'($urandom)};
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), x, st);
        end

        repeat (3) @(posedge clk);
        #2;
        done = 1'b1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
